// File: rtl/rf_alu_sequencer.sv
// Four-phase instruction sequencer (IDLE/READ/EXEC/WB) that drives the register file ports
// and executes one 16-bit instruction at a time through an internal ALU.
module rf_alu_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [ADDR_W-1:0] rf_rd_addr_a,
  output logic [ADDR_W-1:0] rf_rd_addr_b,
  input  logic [DATA_W-1:0] rf_d_out_a,
  input  logic [DATA_W-1:0] rf_d_out_b,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              flag_z,
  output logic              flag_c,
  output logic [15:0]       retire_cnt
);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

  state_e            state_q, state_d;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] result_q, alu_res;
  logic              carry_q, alu_c;
  logic              flag_z_q, flag_c_q;
  logic [15:0]       cnt_q;
  logic [3:0]        op;
  logic              legal, writes, accept;

  assign op     = instr_q[15:12];
  assign legal  = ~op[3];
  assign writes = legal && (op != 4'd7);
  assign accept = (state_q == StIdle) && instr_valid;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      4'd0:    {alu_c, alu_res} = {1'b0, rf_d_out_a} + {1'b0, rf_d_out_b};
      4'd1: begin
        alu_res = rf_d_out_a - rf_d_out_b;
        alu_c   = rf_d_out_a < rf_d_out_b;
      end
      4'd2:    alu_res = rf_d_out_a & rf_d_out_b;
      4'd3:    alu_res = rf_d_out_a | rf_d_out_b;
      4'd4:    alu_res = rf_d_out_a ^ rf_d_out_b;
      4'd5:    alu_res = rf_d_out_a;
      4'd6:    alu_res = {{(DATA_W-9){1'b0}}, instr_q[8:0]};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      instr_q  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) instr_q <= instr;
      // Operands are captured here, before the WB edge, so rd == rs is safe.
      if (state_q == StExec) begin
        result_q <= alu_res;
        carry_q  <= alu_c;
      end
      if (state_q == StWb) begin
        if (writes) flag_z_q <= (result_q == '0);
        if (op == 4'd0 || op == 4'd1) flag_c_q <= carry_q;
        if (legal) cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign instr_ready  = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StWb);
  assign err          = done && !legal;
  assign rf_wr        = done && writes;
  assign rf_rd_addr_a = instr_q[8:6];
  assign rf_rd_addr_b = instr_q[5:3];
  assign rf_wr_addr   = instr_q[11:9];
  assign rf_d_in      = result_q;
  assign flag_z       = flag_z_q;
  assign flag_c       = flag_c_q;
  assign retire_cnt   = cnt_q;

endmodule
